// File: rtl/keypad_pkg.sv
// Shared types and keycode field helpers for the keypad responder.
// Bounce emulation is enabled by defining KPD_BOUNCE_EN.
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 3;
  localparam logic [1:0] KEY_INVALID_COL = 2'b11;

  function automatic logic [1:0] key_col(input logic [3:0] k);
    return k[3:2];
  endfunction

  function automatic logic [1:0] key_row(input logic [3:0] k);
    return k[1:0];
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
// Counter runs 0..TICK_DIV-1; tick is high while it holds the last value.
module keypad_tick_gen #(
  parameter int TICK_DIV = 8000
) (
  input  logic fin,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge fin) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_responder.sv
// 4x3 matrix keypad emulator: presses keys on command, answers row scans.
// Define KPD_BOUNCE_EN to add contact bounce at press and release.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int TICK_DIV     = 8000,
  parameter int GAP_TICKS    = 4,
  parameter int BOUNCE_TICKS = 3
) (
  input  logic        fin,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  input  logic [3:0]  scan,
  output logic [2:0]  colum,
  output logic        pressed,
  output logic        busy,
  output logic        err
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);
  localparam logic [15:0] BNC_LAST = 16'(BOUNCE_TICKS - 1);

  if (GAP_TICKS < 1 || BOUNCE_TICKS < 1) begin : g_cfg_check
    $error("keypad_responder: GAP_TICKS and BOUNCE_TICKS must be >= 1");
  end

  state_t      state;
  logic [3:0]  key;
  logic [15:0] hold_last;
  logic [15:0] cnt;
  logic        contact;
  logic        tick;
  logic [2:0]  col_hot;

  keypad_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .fin  (fin),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge fin) begin
    if (rst) begin
      state     <= S_IDLE;
      key       <= '0;
      hold_last <= '0;
      cnt       <= '0;
      contact   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (key_col(cmd_key) == KEY_INVALID_COL) begin
              err <= 1'b1;
            end else begin
              key <= cmd_key;
              // zero hold is treated as a one-tick hold
              hold_last <= (cmd_hold == 16'd0) ? 16'd0 : cmd_hold - 16'd1;
              cnt <= '0;
`ifdef KPD_BOUNCE_EN
              state <= S_BOUNCE_IN;
`else
              state   <= S_HOLD;
              contact <= 1'b1;
`endif
            end
          end
        end
`ifdef KPD_BOUNCE_EN
        S_BOUNCE_IN: begin
          if (tick) begin
            contact <= ~contact;
            if (cnt == BNC_LAST) begin
              state <= S_HOLD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_BOUNCE_OUT: begin
          if (tick) begin
            contact <= ~contact;
            if (cnt == BNC_LAST) begin
              state <= S_GAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
`endif
        S_HOLD: begin
          if (tick) begin
            if (cnt == hold_last) begin
              cnt <= '0;
`ifdef KPD_BOUNCE_EN
              state <= S_BOUNCE_OUT;
`else
              state   <= S_GAP;
              contact <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (cnt == GAP_LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign col_hot = 3'b001 << key_col(key);

  // only the key's own row strobe matters, as in a real matrix
  always_ff @(posedge fin) begin
    if (rst) begin
      colum <= 3'b111;
    end else if (contact && !scan[key_row(key)]) begin
      colum <= ~col_hot;
    end else begin
      colum <= 3'b111;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign pressed   = contact;

endmodule

// File: tb/tb_keypad_responder.sv
// Bench for keypad_responder: directed tables, corner sequences, random
// traffic against an event-schedule model (follows KPD_BOUNCE_EN).
module tb_keypad_responder;

  localparam int TD = 4;
  localparam int GP = 4;
  localparam int BT = 3;
`ifdef KPD_BOUNCE_EN
  localparam int PER = 2 * BT;
`else
  localparam int PER = 2;
`endif

  logic        fin = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_key = '0;
  logic [15:0] cmd_hold = '0;
  logic [3:0]  scan = 4'hF;
  logic [2:0]  colum;
  logic        pressed;
  logic        busy;
  logic        err;

  keypad_responder #(
    .TICK_DIV(TD), .GAP_TICKS(GP), .BOUNCE_TICKS(BT)
  ) dut (
    .fin(fin), .rst(rst), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_hold(cmd_hold), .scan(scan), .colum(colum),
    .pressed(pressed), .busy(busy), .err(err)
  );

  always #5 fin = ~fin;

  int n_run = 0;
  int n_fail = 0;

  // model: posedge index since reset release, and toggle schedule
  int k = 0;
  int m_end = 0;
  int m_hs = 0;
  int ntg = 0;
  int tg[8];
  logic m_ready = 1'b1;
  logic m_pressed = 1'b0;
  logic m_err = 1'b0;
  logic [2:0] m_colum = 3'b111;
  logic [3:0] m_key = '0;

  int tog;
  logic lastp;

  typedef struct {
    logic [3:0] sc;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // nth tick posedge strictly after posedge a
  function automatic int tk(input int a, input int n);
    int r;
    r = (a + 1) % TD;
    return a + 1 + (TD - 1 - r) + TD * (n - 1);
  endfunction

  task automatic sched(input int a, input int h);
    int hh;
    hh = (h == 0) ? 1 : h;
    ntg = 0;
`ifdef KPD_BOUNCE_EN
    for (int i = 1; i <= BT; i++) begin
      tg[ntg] = tk(a, i);
      ntg++;
    end
    for (int i = 1; i <= BT; i++) begin
      tg[ntg] = tk(a, BT + hh + i);
      ntg++;
    end
    m_end = tk(a, 2 * BT + hh + GP);
    m_hs = tg[BT-1];
`else
    tg[0] = a;
    tg[1] = tk(a, hh);
    ntg = 2;
    m_end = tk(a, hh + GP);
    m_hs = a;
`endif
  endtask

  task automatic model_reset();
    k = 0;
    ntg = 0;
    m_end = 0;
    m_hs = 0;
    m_ready = 1'b1;
    m_pressed = 1'b0;
    m_err = 1'b0;
    m_colum = 3'b111;
  endtask

  task automatic step(input logic v, input logic [3:0] key,
                      input logic [15:0] hold, input logic [3:0] sc);
    logic prev_p;
    int c;
    cmd_valid = v;
    cmd_key = key;
    cmd_hold = hold;
    scan = sc;
    @(posedge fin);
    prev_p = m_pressed;
    m_err = 1'b0;
    if (m_ready && v) begin
      if (key[3:2] == 2'b11) begin
        m_err = 1'b1;
      end else begin
        sched(k, int'(hold));
        m_key = key;
        m_ready = 1'b0;
      end
    end else if (!m_ready && k >= m_end) begin
      m_ready = 1'b1;
    end
    c = 0;
    for (int i = 0; i < ntg; i++) if (tg[i] <= k) c++;
    m_pressed = c[0];
    if (prev_p && !sc[m_key[1:0]])
      m_colum = ~(3'b001 << m_key[3:2]);
    else
      m_colum = 3'b111;
    k++;
    @(negedge fin);
    chk("m_colum", 32'(colum), 32'(m_colum));
    chk("m_pressed", 32'(pressed), 32'(m_pressed));
    chk("m_busy", 32'(busy), 32'(!m_ready));
    chk("m_ready", 32'(cmd_ready), 32'(m_ready));
    chk("m_err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (n) @(posedge fin);
    @(negedge fin);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic obs();
    if (pressed !== lastp) tog++;
    lastp = pressed;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && busy; i++) step(1'b0, 4'h0, 16'd0, 4'hF);
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cp, cc, bad, gapc;
    logic got, pp;

    tbl[0] = '{4'b1011, 3'b101};
    tbl[1] = '{4'b1110, 3'b111};
    tbl[2] = '{4'b0000, 3'b101};
    tbl[3] = '{4'b1111, 3'b111};
    tbl[4] = '{4'b0100, 3'b111};
    tbl[5] = '{4'b0011, 3'b101};

    // reset state
    do_reset(2);
    chk("rst_colum", 32'(colum), 32'h7);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);

    // key col1,row2 hold 5, its row strobed
    tog = 0; lastp = 1'b0; cp = 0; cc = 0;
    step(1'b1, 4'b0110, 16'd5, 4'b1011);
    obs();
    for (int i = 0; i < 400 && busy; i++) begin
      if (pressed) cp++;
      if (colum == 3'b101) cc++;
      step(1'b0, 4'h0, 16'd0, 4'b1011);
      obs();
    end
    if (colum == 3'b101) cc++;
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_toggles", 32'(tog), 32'(PER));
    chk("t2_colum_cycles", 32'(cc), 32'(cp));
`ifndef KPD_BOUNCE_EN
    chk("t2_hold_min", 32'(cp >= 4 * 5 - 3), 32'd1);
    chk("t2_hold_max", 32'(cp <= 4 * 5), 32'd1);
`endif

    // same key, other row strobed: column never pulled low
    cc = 0; cp = 0;
    step(1'b1, 4'b0110, 16'd5, 4'b1110);
    for (int i = 0; i < 400 && busy; i++) begin
      if (pressed) cp++;
      if (colum != 3'b111) cc++;
      step(1'b0, 4'h0, 16'd0, 4'b1110);
    end
    chk("t2b_colum_low", 32'(cc), 32'd0);
    chk("t2b_pressed_seen", 32'(cp > 0), 32'd1);
    drain();

    // key 0000: colum[0] follows pressed one cycle later
    bad = 0; pp = pressed; tog = 0; lastp = pressed;
    step(1'b1, 4'b0000, 16'd3, 4'b1110);
    if (colum[0] !== !pp) bad++;
    obs();
    for (int i = 0; i < 400 && busy; i++) begin
      pp = pressed;
      step(1'b0, 4'h0, 16'd0, 4'b1110);
      if (colum[0] !== !pp) bad++;
      obs();
    end
    chk("t3_follow", 32'(bad), 32'd0);
    chk("t3_toggles", 32'(tog), 32'(PER));
    drain();

    // back-to-back: second command held off until gap elapses
    tog = 0; lastp = pressed; gapc = 0; got = 1'b0;
    step(1'b1, 4'b0001, 16'd2, 4'hF);
    obs();
    for (int i = 0; i < 600 && !got; i++) begin
      step(1'b1, 4'b0010, 16'd2, 4'hF);
      obs();
      if (tog == PER && !pressed) gapc++;
      if (tog == PER + 1) got = 1'b1;
    end
    chk("t4_second_press", 32'(got), 32'd1);
    chk("t4_gap_min", 32'(gapc >= GP * TD), 32'd1);
`ifndef KPD_BOUNCE_EN
    chk("t4_gap_exact", 32'(gapc), 32'd17);
`endif
    drain();

    // invalid keycode
    step(1'b1, 4'b1101, 16'd3, 4'h0);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_colum", 32'(colum), 32'h7);
    step(1'b0, 4'h0, 16'd0, 4'h0);
    chk("t5_err_once", 32'(err), 32'd0);

    // column table while key 0110 is held
    step(1'b1, 4'b0110, 16'd40, 4'hF);
    for (int i = 0; i < 100 && k <= m_hs + 1; i++)
      step(1'b0, 4'h0, 16'd0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'h0, 16'd0, tbl[i].sc);
      chk($sformatf("tbl_%0d", i), 32'(colum), 32'(tbl[i].exp));
    end
    drain();

    // reset in the middle of a hold
    step(1'b1, 4'b0000, 16'd20, 4'b1110);
    for (int i = 0; i < 200 && colum !== 3'b110; i++)
      step(1'b0, 4'h0, 16'd0, 4'b1110);
    chk("t6_pre", 32'(colum), 32'h6);
    do_reset(1);
    chk("t6_colum", 32'(colum), 32'h7);
    chk("t6_pressed", 32'(pressed), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    step(1'b1, 4'b0110, 16'd2, 4'hF);
    chk("t6_accept", 32'(busy), 32'd1);
    drain();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, 4'($urandom), 16'($urandom_range(0, 3)),
           4'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
